// File: rtl/y86_pkg.sv
// Constants and field widths shared by the Y86 pipeline registers (F/D/E/M/W).
package y86_pkg;

    localparam int unsigned DATA_W_DFLT = 64;
    localparam int unsigned REG_W_DFLT  = 4;
    localparam int unsigned STAT_W_DFLT = 3;
    localparam int unsigned CNT_W_DFLT  = 16;

    localparam logic [3:0]             INOP  = 4'h1;
    localparam logic [STAT_W_DFLT-1:0] SAOK  = 3'd1;
    // Wide all-ones constant; users slice it down to their register-ID width.
    localparam logic [31:0]            RNONE = '1;

    // Action a pipeline register takes on the next edge (reset handled separately).
    typedef enum logic [1:0] {
        CtlLoad,
        CtlHold,
        CtlBubble
    } ctl_e;

    // Bubble beats stall; stall beats a normal load.
    function automatic ctl_e ctl_decode(input logic stall, input logic bubble);
        if (bubble) begin
            return CtlBubble;
        end else if (stall) begin
            return CtlHold;
        end
        return CtlLoad;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Decode-to-execute bundle: d_* fields in, registered E_* fields out.
interface pipe_stage_reg_if
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned REG_W  = REG_W_DFLT,
    parameter int unsigned STAT_W = STAT_W_DFLT
);
    logic [STAT_W-1:0] d_stat;
    logic [3:0]        d_icode;
    logic [3:0]        d_ifun;
    logic [DATA_W-1:0] d_valC;
    logic [DATA_W-1:0] d_valA;
    logic [DATA_W-1:0] d_valB;
    logic [REG_W-1:0]  d_dstE;
    logic [REG_W-1:0]  d_dstM;
    logic [REG_W-1:0]  d_srcA;
    logic [REG_W-1:0]  d_srcB;

    logic [STAT_W-1:0] E_stat;
    logic [3:0]        E_icode;
    logic [3:0]        E_ifun;
    logic [DATA_W-1:0] E_valC;
    logic [DATA_W-1:0] E_valA;
    logic [DATA_W-1:0] E_valB;
    logic [REG_W-1:0]  E_dstE;
    logic [REG_W-1:0]  E_dstM;
    logic [REG_W-1:0]  E_srcA;
    logic [REG_W-1:0]  E_srcB;
    logic              E_valid;

    modport master (
        output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB,
        input  E_valid
    );

    modport slave (
        input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB,
        output E_valid
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MaxCnt = '1;

    logic [CNT_W-1:0] r_count;

    // Clear overrides a same-cycle increment; stick at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != MaxCnt)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Decode/execute pipeline register with stall, bubble and event counters.
module pipe_stage_reg
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned REG_W  = REG_W_DFLT,
    parameter int unsigned STAT_W = STAT_W_DFLT,
    parameter int unsigned CNT_W  = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bubble,
    input  logic             clr_cnt,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             ctl_err
);

    localparam logic [REG_W-1:0]  RegNone = RNONE[REG_W-1:0];
    localparam logic [STAT_W-1:0] StatOk  = STAT_W'(SAOK);

    ctl_e              w_ctl;
    logic [STAT_W-1:0] r_stat;
    logic [3:0]        r_icode;
    logic [3:0]        r_ifun;
    logic [DATA_W-1:0] r_valC;
    logic [DATA_W-1:0] r_valA;
    logic [DATA_W-1:0] r_valB;
    logic [REG_W-1:0]  r_dstE;
    logic [REG_W-1:0]  r_dstM;
    logic [REG_W-1:0]  r_srcA;
    logic [REG_W-1:0]  r_srcB;
    logic              r_valid;
    logic              r_ctl_err;

    assign w_ctl = ctl_decode(stall, bubble);

    // Reset and bubble both insert a nop; hold leaves every field untouched.
    always_ff @(posedge clk) begin
        if (!rst_n || (w_ctl == CtlBubble)) begin
            r_stat  <= StatOk;
            r_icode <= INOP;
            r_ifun  <= 4'h0;
            r_valC  <= '0;
            r_valA  <= '0;
            r_valB  <= '0;
            r_dstE  <= RegNone;
            r_dstM  <= RegNone;
            r_srcA  <= RegNone;
            r_srcB  <= RegNone;
            r_valid <= 1'b0;
        end else if (w_ctl == CtlLoad) begin
            r_stat  <= bus.d_stat;
            r_icode <= bus.d_icode;
            r_ifun  <= bus.d_ifun;
            r_valC  <= bus.d_valC;
            r_valA  <= bus.d_valA;
            r_valB  <= bus.d_valB;
            r_dstE  <= bus.d_dstE;
            r_dstM  <= bus.d_dstM;
            r_srcA  <= bus.d_srcA;
            r_srcB  <= bus.d_srcB;
            r_valid <= 1'b1;
        end
    end

    // Flag a conflicting stall+bubble request for exactly the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctl_err <= 1'b0;
        end else begin
            r_ctl_err <= stall && bubble;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (stall && !bubble),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (bubble),
        .count (bubble_cnt)
    );

    assign bus.E_stat  = r_stat;
    assign bus.E_icode = r_icode;
    assign bus.E_ifun  = r_ifun;
    assign bus.E_valC  = r_valC;
    assign bus.E_valA  = r_valA;
    assign bus.E_valB  = r_valB;
    assign bus.E_dstE  = r_dstE;
    assign bus.E_dstM  = r_dstM;
    assign bus.E_srcA  = r_srcA;
    assign bus.E_srcB  = r_srcB;
    assign bus.E_valid = r_valid;
    assign ctl_err     = r_ctl_err;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes expectations, a monitor pops and checks.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } fields_t;

    typedef struct {
        string   tag;
        fields_t f;
        logic    valid;
        logic [2:0] sc;
        logic [2:0] bc;
        logic    err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       bubble;
    logic       clr_cnt;
    logic [2:0] stall_cnt;
    logic [2:0] bubble_cnt;
    logic       ctl_err;

    int n_checks = 0;
    int n_errors = 0;

    exp_t    sb_q[$];
    fields_t m_f;
    logic    m_valid;
    logic [2:0] m_sc;
    logic [2:0] m_bc;
    logic    m_err;

    pipe_stage_reg_if #(.DATA_W(64), .REG_W(4), .STAT_W(3)) bus ();

    pipe_stage_reg #(
        .DATA_W (64),
        .REG_W  (4),
        .STAT_W (3),
        .CNT_W  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .bubble     (bubble),
        .clr_cnt    (clr_cnt),
        .bus        (bus),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .ctl_err    (ctl_err)
    );

    always #5 clk = ~clk;

    function automatic fields_t nop_f();
        fields_t f;
        f = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, valC: 64'h0, valA: 64'h0, valB: 64'h0,
              dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF};
        return f;
    endfunction

    function automatic fields_t mk(input logic [2:0] stat, input logic [3:0] icode,
                                   input logic [3:0] ifun, input logic [63:0] valC,
                                   input logic [63:0] valA, input logic [63:0] valB,
                                   input logic [3:0] dstE, input logic [3:0] dstM,
                                   input logic [3:0] srcA, input logic [3:0] srcB);
        fields_t f;
        f = '{stat: stat, icode: icode, ifun: ifun, valC: valC, valA: valA, valB: valB,
              dstE: dstE, dstM: dstM, srcA: srcA, srcB: srcB};
        return f;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Drive one cycle of stimulus and push the state expected after the next edge.
    task automatic step(input logic rn, input logic st, input logic bb, input logic cl,
                        input fields_t d, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n         = rn;
        stall         = st;
        bubble        = bb;
        clr_cnt       = cl;
        bus.d_stat    = d.stat;
        bus.d_icode   = d.icode;
        bus.d_ifun    = d.ifun;
        bus.d_valC    = d.valC;
        bus.d_valA    = d.valA;
        bus.d_valB    = d.valB;
        bus.d_dstE    = d.dstE;
        bus.d_dstM    = d.dstM;
        bus.d_srcA    = d.srcA;
        bus.d_srcB    = d.srcB;
        if (!rn) begin
            m_f = nop_f(); m_valid = 1'b0; m_sc = 3'd0; m_bc = 3'd0; m_err = 1'b0;
        end else begin
            if (bb) begin
                m_f = nop_f(); m_valid = 1'b0;
            end else if (!st) begin
                m_f = d; m_valid = 1'b1;
            end
            m_err = st & bb;
            if (cl) begin
                m_sc = 3'd0; m_bc = 3'd0;
            end else begin
                if (st && !bb && m_sc != 3'd7) m_sc = m_sc + 3'd1;
                if (bb && m_bc != 3'd7) m_bc = m_bc + 3'd1;
            end
        end
        e.tag = tag; e.f = m_f; e.valid = m_valid; e.sc = m_sc; e.bc = m_bc; e.err = m_err;
        sb_q.push_back(e);
    endtask

    // Monitor: the stage presents a new registered state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.tag, ".stat"},  64'(bus.E_stat),  64'(e.f.stat));
                chk({e.tag, ".icode"}, 64'(bus.E_icode), 64'(e.f.icode));
                chk({e.tag, ".ifun"},  64'(bus.E_ifun),  64'(e.f.ifun));
                chk({e.tag, ".valC"},  bus.E_valC,       e.f.valC);
                chk({e.tag, ".valA"},  bus.E_valA,       e.f.valA);
                chk({e.tag, ".valB"},  bus.E_valB,       e.f.valB);
                chk({e.tag, ".dstE"},  64'(bus.E_dstE),  64'(e.f.dstE));
                chk({e.tag, ".dstM"},  64'(bus.E_dstM),  64'(e.f.dstM));
                chk({e.tag, ".srcA"},  64'(bus.E_srcA),  64'(e.f.srcA));
                chk({e.tag, ".srcB"},  64'(bus.E_srcB),  64'(e.f.srcB));
                chk({e.tag, ".valid"}, 64'(bus.E_valid), 64'(e.valid));
                chk({e.tag, ".stall_cnt"},  64'(stall_cnt),  64'(e.sc));
                chk({e.tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e.bc));
                chk({e.tag, ".ctl_err"},    64'(ctl_err),    64'(e.err));
            end
        end
    end

    initial begin
        fields_t z;
        z = mk(3'd0, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        m_f = nop_f(); m_valid = 1'b0; m_sc = 3'd0; m_bc = 3'd0; m_err = 1'b0;

        step(1'b0, 1'b0, 1'b0, 1'b0, z, "rst0");
        step(1'b0, 1'b1, 1'b1, 1'b1, mk(3'd2, 4'h6, 4'h1, 64'h9, 64'h9, 64'h9,
             4'h1, 4'h1, 4'h1, 4'h1), "rst_all_ctl");
        // Normal load; stat 3 must pass through uninterpreted.
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd3, 4'h6, 4'h2, 64'h11, 64'h5, 64'h7,
             4'h3, 4'h4, 4'h1, 4'h2), "load");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd1, 4'h3, 4'h0, 64'hDEAD, 64'h1, 64'h2,
             4'h5, 4'h6, 4'h7, 4'h8), "load_dead");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, z, $sformatf("stall%0d", i));
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, z, "bubble");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd4, 4'h2, 4'h3, 64'hA, 64'hB, 64'hC,
             4'h9, 4'hA, 4'hB, 4'hC), "load2");
        step(1'b1, 1'b1, 1'b1, 1'b0, z, "conflict");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd1, 4'h7, 4'h1, 64'h123, 64'h456, 64'h789,
             4'h0, 4'h2, 4'hE, 4'hD), "after_conflict");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, z, $sformatf("sat%0d", i));
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, z, "clr_stall");
        step(1'b1, 1'b0, 1'b1, 1'b1, z, "clr_bubble");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd1, 4'h5, 4'h0, 64'hFFFF_0000_1234_5678,
             64'h1, 64'h2, 4'h1, 4'h2, 4'h3, 4'h4), "load3");
        step(1'b1, 1'b1, 1'b0, 1'b0, z, "stall_pre_rst");
        step(1'b0, 1'b1, 1'b0, 1'b0, z, "rst_mid_stall");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd2, 4'h8, 4'h4, 64'h77, 64'h88, 64'h99,
             4'h6, 4'h7, 4'h8, 4'h9), "post_rst_load");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have the parameter `DATA_W`, default 64, setting the width of the valC, valA and valB fields.
REQ-002 The block SHALL have the parameter `REG_W`, default 4, setting the width of the dstE, dstM, srcA and srcB register IDs.
REQ-003 The block SHALL have the parameter `STAT_W`, default 3, setting the width of the status field.
REQ-004 The block SHALL have the parameter `CNT_W`, default 16, setting the width of the stall and bubble counters.
REQ-005 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port `rst_n`, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port `stall`, input, 1 bit: hold the current contents.
REQ-008 The block SHALL have port `bubble`, input, 1 bit: load a nop.
REQ-009 The block SHALL have port `clr_cnt`, input, 1 bit: synchronous clear of both counters.
REQ-010 The block SHALL have these data inputs from the decode stage:
- `d_stat`, STAT_W bits.
- `d_icode` and `d_ifun`, 4 bits each.
- `d_valC`, `d_valA` and `d_valB`, DATA_W bits each.
- `d_dstE`, `d_dstM`, `d_srcA` and `d_srcB`, REG_W bits each.
REQ-011 The block SHALL have the registered outputs `E_stat`, `E_icode`, `E_ifun`, `E_valC`, `E_valA`, `E_valB`, `E_dstE`, `E_dstM`, `E_srcA` and `E_srcB`, with widths matching the d_* inputs.
REQ-012 The block SHALL have output `E_valid`, 1 bit: the stage holds a real instruction rather than a bubble or reset value.
REQ-013 The block SHALL have output `stall_cnt`, CNT_W bits: the number of cycles on which the register held.
REQ-014 The block SHALL have output `bubble_cnt`, CNT_W bits: the number of bubbles inserted.
REQ-015 The block SHALL have output `ctl_err`, 1 bit: a one-cycle pulse reporting that stall and bubble were both asserted.

Function
REQ-016 All outputs SHALL be registered, with a latency of 1 cycle from the d_* inputs to the E_* outputs; there SHALL be no combinational path from input to output.
REQ-017 The register SHALL apply this priority at each rising edge: reset, then bubble, then stall, then normal load.
REQ-018 On a normal load (stall=0, bubble=0), all E_* fields SHALL take the d_* values, including E_dstM, and E_valid SHALL become 1.
REQ-019 On a bubble, the register SHALL load these nop values and set E_valid to 0:
- icode = INOP (4'h1), ifun = 0, stat = SAOK (1).
- valC, valA and valB = 0.
- dstE, dstM, srcA and srcB = RNONE (all ones).
REQ-020 On a stall (bubble=0), all E_* fields and E_valid SHALL hold their previous values.
REQ-021 When stall=1 and bubble=1 together, bubble SHALL win, stall_cnt SHALL NOT increment, bubble_cnt SHALL increment, and ctl_err SHALL be 1 in the following cycle only.
REQ-022 ctl_err SHALL be 0 in every other cycle.
REQ-023 stall_cnt SHALL increment by 1 on each cycle with stall=1 and bubble=0.
REQ-024 bubble_cnt SHALL increment by 1 on each cycle with bubble=1.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-026 clr_cnt=1 SHALL zero both counters on the next edge, overriding a same-cycle increment, and SHALL NOT affect the pipeline fields, E_valid or ctl_err.
REQ-027 The stat value SHALL pass through unmodified; the block does not interpret the Y86 status codes.

Reset
REQ-028 With rst_n=0 at a rising edge, all E_* fields SHALL take the bubble values from REQ-019.
REQ-029 With rst_n=0 at a rising edge, E_valid, ctl_err, stall_cnt and bubble_cnt SHALL all be 0.
REQ-030 Reset SHALL override stall, bubble and clr_cnt, including reset asserted while a stall is in progress.
REQ-031 On the first edge after rst_n rises, the normal priority rules SHALL apply.

Structure
REQ-032 The constants INOP, SAOK and RNONE, and the default field widths, SHALL reside in the shared package y86_pkg, which the other pipeline registers (F/D/M/W) also use.
REQ-033 A single sub-module, sat_counter (parameter CNT_W; ports clk, rst_n, clr, inc, count), SHALL be instantiated twice: once for stall_cnt and once for bubble_cnt.
REQ-034 The block SHALL use no latches.

Verification
REQ-035 Normal load: drive d_icode=6, d_valA=64'h5, d_dstE=3 with stall=0 and bubble=0. One edge later, E_icode=6, E_valA=5, E_dstE=3 and E_valid=1.
REQ-036 Stall hold: load d_valC=64'hDEAD, then hold stall=1 for 3 cycles while d_valC=0. E_valC stays 64'hDEAD throughout and stall_cnt=3.
REQ-037 Bubble: assert bubble=1 for 1 cycle. The register shows E_icode=1, E_dstE=E_dstM=4'hF, E_valA=0, E_stat=1 and E_valid=0, and bubble_cnt increments by 1.
REQ-038 Conflict: assert stall=1 and bubble=1 together. The register shows the nop values, ctl_err is 1 for exactly 1 cycle, and stall_cnt is unchanged.
REQ-039 Saturation and clear: with CNT_W=3, hold stall for 10 cycles and stall_cnt=7. Then assert clr_cnt together with stall; stall_cnt=0 and the fields still hold.
REQ-040 Reset mid-stall: assert rst_n=0 with stall=1. One edge later, every output equals its reset value from REQ-028 and REQ-029.
